// File: rtl/dbus_sram_responder_pkg.sv
// -----------------------------------------------------------------------------
// dbus_sram_responder_pkg
// Shared types and helpers for the data-bus SRAM responder.
//   msize_t        : access size encoding (MSIZE1 / MSIZE2 / MSIZE4)
//   state_t        : responder FSM states (IDLE / WAIT / RESP)
//   lane_mask()    : byte strobe implied by an access size and address[1:0]
//   proto_violation(): misalignment or strobe/size disagreement check
// -----------------------------------------------------------------------------
package dbus_sram_responder_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Strobe pattern a well-formed store of this size/offset must carry.
    function automatic logic [3:0] lane_mask(input msize_t size, input logic [1:0] addr_lo);
        logic [3:0] mask;
        case (size)
            MSIZE1:  mask = 4'b0001 << addr_lo;
            MSIZE2:  mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            MSIZE4:  mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // True when the request is misaligned or its strobe does not match its size.
    function automatic logic proto_violation(input msize_t size, input logic [1:0] addr_lo,
                                             input logic [3:0] strobe);
        logic bad;
        case (size)
            MSIZE4:  bad = (addr_lo != 2'b00);
            MSIZE2:  bad = addr_lo[0];
            MSIZE1:  bad = 1'b0;
            default: bad = 1'b1;
        endcase
        if ((strobe != 4'b0000) && (strobe != lane_mask(size, addr_lo))) begin
            bad = 1'b1;
        end else begin
            bad = bad;
        end
        return bad;
    endfunction

endpackage

// File: rtl/dbus_sram_responder_if.sv
// -----------------------------------------------------------------------------
// dbus_sram_responder_if
// Request/response bundle between the memory stage (master) and the SRAM
// responder (slave).
//   req_valid/req_addr/req_size/req_strobe/req_data : request, master -> slave
//   resp_addr_ok/resp_data_ok/resp_data             : handshake and read word
//   proto_err                                       : sticky violation flag
// -----------------------------------------------------------------------------
interface dbus_sram_responder_if;
    import dbus_sram_responder_pkg::*;

    logic        req_valid;
    logic [31:0] req_addr;
    msize_t      req_size;
    logic [3:0]  req_strobe;
    logic [31:0] req_data;
    logic        resp_addr_ok;
    logic        resp_data_ok;
    logic [31:0] resp_data;
    logic        proto_err;

    modport master (
        output req_valid, req_addr, req_size, req_strobe, req_data,
        input  resp_addr_ok, resp_data_ok, resp_data, proto_err
    );

    modport slave (
        input  req_valid, req_addr, req_size, req_strobe, req_data,
        output resp_addr_ok, resp_data_ok, resp_data, proto_err
    );

endinterface

// File: rtl/dbus_sram_bank.sv
// -----------------------------------------------------------------------------
// dbus_sram_bank
// Word-organised single-port RAM, 2**DEPTH_LOG2 x 32 bits, byte write enables,
// synchronous read. Contents are not reset.
//   clk     : clock
//   addr_i  : word index
//   we_i    : per-byte write enables
//   wdata_i : write data (lane i in bits 8i+7:8i)
//   re_i    : read enable; rdata_o updates only when set
//   rdata_o : registered read word, held between reads
// -----------------------------------------------------------------------------
module dbus_sram_bank #(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [3:0]            we_i,
    input  logic [31:0]           wdata_i,
    input  logic                  re_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_q [2**DEPTH_LOG2];
    logic [31:0] rdata_q;

    // Byte-lane writes and registered read of the addressed word.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) begin
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dbus_sram_responder.sv
// -----------------------------------------------------------------------------
// dbus_sram_responder
// Responder end of the data-bus protocol: accepts one request at a time and
// serves it from an internal RAM LATENCY cycles after acceptance.
//   clk     : clock, rising edge
//   resetn  : synchronous active-low reset
//   bus     : dbus_sram_responder_if.slave (request in, addr_ok/data_ok/data out,
//             sticky proto_err)
// Parameters: DEPTH_LOG2 (RAM depth), LATENCY (1..15), LFSR_SEED.
// Optional build macro DBUS_STALL_INJECT_EN: pseudo-random stalls on accept
// and in WAIT, driven by a 16-bit LFSR; data and ordering are unaffected.
// -----------------------------------------------------------------------------
module dbus_sram_responder
    import dbus_sram_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 resetn,
    dbus_sram_responder_if.slave bus
);

    // Counter load value; zero means the accept edge is also the access edge.
    localparam logic [3:0] LOAD_CNT = 4'(LATENCY - 1);

    state_t                state_q,  state_d;
    logic [3:0]            cnt_q,    cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q,    idx_d;
    logic [3:0]            strobe_q, strobe_d;
    logic [31:0]           data_q,   data_d;
    logic                  perr_q,   perr_d;
    logic                  dok_q,    dok_d;
    logic                  rd_resp_q, rd_resp_d;

    logic                  accept_s;
    logic                  accept_gate_s;
    logic                  dec_gate_s;
    logic                  access_s;
    logic [DEPTH_LOG2-1:0] req_idx_s;
    logic [DEPTH_LOG2-1:0] acc_idx_s;
    logic [3:0]            acc_strobe_s;
    logic [31:0]           acc_data_s;
    logic [3:0]            bank_we_s;
    logic                  bank_re_s;
    logic [31:0]           bank_rdata_s;
    logic                  unused_addr_hi_s;

`ifdef DBUS_STALL_INJECT_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb_s;

    // Next value of the stall LFSR (taps 16,14,13,11), reseeded on reset.
    always_comb begin
        lfsr_fb_s = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        if (!resetn) begin
            lfsr_d = LFSR_SEED;
        end else begin
            lfsr_d = {lfsr_q[14:0], lfsr_fb_s};
        end
    end

    // Stall LFSR register.
    always_ff @(posedge clk) begin
        lfsr_q <= lfsr_d;
    end

    assign accept_gate_s = lfsr_q[0];
    assign dec_gate_s    = lfsr_q[1];
`else
    logic unused_seed_s;
    assign unused_seed_s = ^LFSR_SEED;
    assign accept_gate_s = 1'b1;
    assign dec_gate_s    = 1'b1;
`endif

    // Upper address bits alias onto the RAM and are deliberately dropped.
    assign unused_addr_hi_s = ^bus.req_addr[31:DEPTH_LOG2+2];
    assign req_idx_s        = bus.req_addr[DEPTH_LOG2+1:2];

    // A request is taken only in IDLE and never while reset is asserted.
    assign accept_s         = resetn & bus.req_valid & (state_q == IDLE) & accept_gate_s;

    // FSM next-state, request latch, access strobe and response flags.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        strobe_d     = strobe_q;
        data_d       = data_q;
        perr_d       = perr_q;
        dok_d        = 1'b0;
        rd_resp_d    = rd_resp_q;
        access_s     = 1'b0;
        acc_idx_s    = idx_q;
        acc_strobe_s = strobe_q;
        acc_data_s   = data_q;

        if (!resetn) begin
            state_d   = IDLE;
            cnt_d     = 4'd0;
            idx_d     = '0;
            strobe_d  = 4'h0;
            data_d    = 32'h0;
            perr_d    = 1'b0;
            rd_resp_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        idx_d    = req_idx_s;
                        strobe_d = bus.req_strobe;
                        data_d   = bus.req_data;
                        perr_d   = perr_q | proto_violation(bus.req_size, bus.req_addr[1:0],
                                                            bus.req_strobe);
                        if (LOAD_CNT == 4'd0) begin
                            // Single-cycle latency: access straight from the live request.
                            state_d      = RESP;
                            cnt_d        = 4'd0;
                            access_s     = 1'b1;
                            acc_idx_s    = req_idx_s;
                            acc_strobe_s = bus.req_strobe;
                            acc_data_s   = bus.req_data;
                        end else begin
                            state_d = WAIT;
                            cnt_d   = LOAD_CNT;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                WAIT: begin
                    if (dec_gate_s) begin
                        // The decrement that reaches zero is the access edge.
                        if (cnt_q == 4'd1) begin
                            state_d  = RESP;
                            cnt_d    = 4'd0;
                            access_s = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                RESP: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (access_s) begin
                dok_d     = 1'b1;
                rd_resp_d = (acc_strobe_s == 4'h0);
            end else begin
                dok_d     = 1'b0;
                rd_resp_d = rd_resp_q;
            end
        end
    end

    // State and response registers (reset is folded into the _d logic above).
    always_ff @(posedge clk) begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        idx_q     <= idx_d;
        strobe_q  <= strobe_d;
        data_q    <= data_d;
        perr_q    <= perr_d;
        dok_q     <= dok_d;
        rd_resp_q <= rd_resp_d;
    end

    assign bank_we_s = access_s ? acc_strobe_s : 4'h0;
    assign bank_re_s = access_s & (acc_strobe_s == 4'h0);

    dbus_sram_bank #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_bank (
        .clk     (clk),
        .addr_i  (acc_idx_s),
        .we_i    (bank_we_s),
        .wdata_i (acc_data_s),
        .re_i    (bank_re_s),
        .rdata_o (bank_rdata_s)
    );

    assign bus.resp_addr_ok = accept_s;
    assign bus.resp_data_ok = dok_q;
    // The bank read register only moves on reads; writes report zero instead.
    assign bus.resp_data    = rd_resp_q ? bank_rdata_s : 32'h0;
    assign bus.proto_err    = perr_q;

endmodule

// File: doc/dbus_sram_responder.md
Name: dbus_sram_responder

Overview:
Responder end of the core's data-bus request/response protocol. The memory stage raises a request carrying valid, address, size, byte strobe and write data, and expects a full 32-bit read word back. This block accepts one request at a time, serves it from an internal word-organised synchronous RAM after a fixed configurable latency, and returns addr_ok/data_ok handshakes. It serves as the data-side memory model for simulation and small FPGA builds, sitting directly behind the memory stage.

Parameters:
- DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words (index = req_addr[DEPTH_LOG2+1:2]).
- LATENCY, 2, cycles from the accept cycle to the data_ok cycle; legal range 1..15.
- LFSR_SEED, 16'hACE1, nonzero seed for the stall-injection LFSR (used only with the optional feature).

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- resetn, input, 1, reset, synchronous, active-low.
- req_valid, input, 1, request present; held stable by the initiator until addr_ok.
- req_addr, input, 32, byte address.
- req_size, input, msize_t, access size (MSIZE1/2/4).
- req_strobe, input, 4, byte write enables; 0 means read.
- req_data, input, 32, write data, already lane-replicated by the initiator.
- resp_addr_ok, output, 1, request accepted this cycle.
- resp_data_ok, output, 1, one-cycle pulse; response valid.
- resp_data, output, 32, full read word; 0 for writes.
- proto_err, output, 1, sticky protocol-violation flag.

Behaviour:
- FSM states: IDLE, WAIT, RESP. Reset puts the FSM in IDLE and clears counter, latched request, resp_data, resp_data_ok and proto_err. resp_addr_ok is 0 while resetn=0. RAM contents are not reset.
- Accept: resp_addr_ok = req_valid & (state==IDLE), combinational. On an accept edge the block latches addr, strobe, data and size, and loads the counter with LATENCY-1.
  - If LATENCY-1 == 0, the FSM goes directly to RESP.
  - Otherwise it goes to WAIT and decrements the counter each cycle; at counter==0 it goes to RESP.
- Access cycle: the edge entering RESP.
  - Write (strobe≠0): each byte lane i with strobe[i]=1 takes data[8i+7:8i]; resp_data is set to 0.
  - Read: resp_data is set to the RAM word at the index.
- RESP: resp_data_ok=1 for exactly one cycle, then IDLE. resp_data holds its value until the next access cycle.
- Latency and throughput: accept at cycle T gives data_ok at T+LATENCY. The next accept is possible at T+LATENCY+1, so throughput is one request per LATENCY+1 cycles.
- Requests are ignored, with addr_ok=0, in WAIT and RESP. The initiator keeps valid high.
- Address bits above DEPTH_LOG2+1 are ignored, so the RAM aliases. addr[1:0] does not change the index. Reads always return the whole word; the initiator extracts the lanes.
- proto_err is set at accept (sticky until reset) for any of:
  - size=MSIZE4 with addr[1:0]≠0;
  - size=MSIZE2 with addr[0]≠0;
  - strobe≠0 and strobe not equal to the lane mask implied by size/addr[1:0] (MSIZE1 → 1<<addr[1:0]; MSIZE2 → 4'b0011 or 4'b1100; MSIZE4 → 4'b1111).
  The access proceeds normally regardless of proto_err.
- Reset mid-operation: a pending write that has not reached its access cycle is dropped, and no data_ok is issued.
- Simultaneous reset and accept: reset wins.

Optional Feature:
- Macro: DBUS_STALL_INJECT_EN.
- When defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11, seeded with LFSR_SEED on reset) advances every cycle. resp_addr_ok additionally requires lfsr[0]=1. In WAIT, the counter decrements only when lfsr[1]=1. Data and ordering are unchanged; only the timing is stretched.
- When undefined: no LFSR is built and timing is exactly as above.

Decomposition:
- Shared package: msize_t (MSIZE1/2/4), the FSM state enum, and a function lane_mask(size, addr[1:0]) returning the expected strobe.
- One sub-module: dbus_sram_bank, a DEPTH-word × 32-bit RAM with per-byte write enables and a synchronous read port.

Test Plan:
- Reset, then read addr 0x0000_0010 with LATENCY=2 → addr_ok in cycle T, data_ok only in T+2; proto_err=0.
- SW 0xDEADBEEF at 0x40 (strobe 1111, MSIZE4), then LW 0x40 → resp_data 0xDEADBEEF; the write's own response returns resp_data 0.
- SB 0x{4{8'hAA}} at 0x42 (strobe 0100) over 0x11223344, then LW 0x40 → 0x11AA3344.
- SH at 0x41 (MSIZE2, strobe 0011) → proto_err rises the cycle after accept and stays 1 after subsequent legal accesses.
- A second valid request held during WAIT → addr_ok stays 0 until the cycle after data_ok; both complete in order. Assert resetn=0 during WAIT of a write → no data_ok, and a later read shows the old word.
- With DBUS_STALL_INJECT_EN defined, 200 random SW/LW pairs against a scoreboard → all data matches; every latency is at least LATENCY.
